// File: rtl/risc_mc_core_pkg.sv
// Shared definitions for the multi-cycle RISC core:
// opcodes, FSM states, ALU op encoding, instruction fields.
package risc_mc_core_pkg;

  localparam logic [3:0] OP_LW   = 4'h0;
  localparam logic [3:0] OP_SW   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_ILA  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_J    = 4'hD;
  localparam logic [3:0] OP_ILE  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB  = 12;
  localparam int RA_LSB  = 9;
  localparam int RB_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int IMM6_W  = 6;
  localparam int IMM12_W = 12;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/risc_mc_alu.sv
// Combinational ALU; shifts use only the low log2(DATA_W)
// bits of b, comparisons are unsigned.
module risc_mc_alu
  import risc_mc_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;

  assign sh = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NOT: result = ~a;
      ALU_SHL: result = a << sh;
      ALU_SHR: result = a >> sh;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, a < b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/risc_mc_core.sv
// Multi-cycle 16-bit-instruction RISC core with
// req/ack instruction and data ports.
module risc_mc_core
  import risc_mc_core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              i_req,
  output logic [PC_W-1:0]   i_addr,
  input  logic [15:0]       i_rdata,
  input  logic              i_ack,
  output logic              d_req,
  output logic              d_we,
  output logic [DATA_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  input  logic              d_ack,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc_o
);

  state_e state, state_nx;

  logic [15:0]               ir;
  logic [PC_W-1:0]           pc;
  logic [7:0][DATA_W-1:0]    rf;
  logic [DATA_W-1:0]         opa, opb, res;
  logic                      ill_q;
  logic                      boot;

  logic [3:0]                op;
  logic [2:0]                ra, rb, rd, dst;
  logic [IMM6_W-1:0]         imm6;
  logic [IMM12_W-1:0]        imm12;
  logic [DATA_W-1:0]         imm, ra_val, rb_val;
  logic [DATA_W-1:0]         alu_b, alu_y;
  logic [PC_W-1:0]           pc2, br_tgt, j_tgt;
  logic                      is_alu, is_mem, is_flow;
  logic                      is_bad, taken;

  assign op    = ir[OP_LSB +: 4];
  assign ra    = ir[RA_LSB +: 3];
  assign rb    = ir[RB_LSB +: 3];
  assign rd    = ir[RD_LSB +: 3];
  assign imm6  = ir[0 +: IMM6_W];
  assign imm12 = ir[0 +: IMM12_W];
  assign imm   = {{(DATA_W-IMM6_W){imm6[IMM6_W-1]}}, imm6};

  assign is_alu  = (op >= OP_ADD) && (op <= OP_SLT);
  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_flow = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  assign is_bad  = (op == OP_ILA) || (op == OP_ILE);
  assign dst     = (op == OP_LW) ? rb : rd;

  assign ra_val = (ra == 3'd0) ? '0 : rf[ra];
  assign rb_val = (rb == 3'd0) ? '0 : rf[rb];

  // Branch decision is a plain operand compare, independent of the ALU.
  assign taken = (opa == opb) ^ (op == OP_BNE);

  assign pc2    = pc + PC_W'(2);
  assign br_tgt = pc2 + {{(PC_W-IMM6_W-1){imm6[IMM6_W-1]}}, imm6, 1'b0};
  assign j_tgt  = {pc2[PC_W-1:13], imm12, 1'b0};

  assign alu_b = is_mem ? imm : opb;

  risc_mc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (opa),
    .b      (alu_b),
    .op     (is_mem ? ALU_ADD : alu_op_of(op)),
    .result (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:
        if (i_req && i_ack) state_nx = S_DECODE;
      S_DECODE:
        state_nx = (op == OP_HALT || is_bad) ? S_HALT : S_EXEC;
      S_EXEC:
        unique case (1'b1)
          is_alu:  state_nx = S_WB;
          is_mem:  state_nx = S_MEM;
          default: state_nx = S_FETCH;
        endcase
      S_MEM:
        if (d_ack) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:
        state_nx = S_FETCH;
      S_HALT:
        state_nx = S_HALT;
      default:
        state_nx = S_FETCH;
    endcase
  end

  // boot keeps the fetch request low for the cycle after reset,
  // so an ack for an aborted fetch can never be taken.
  always_comb begin
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    retire  = 1'b0;
    halted  = 1'b0;
    unique case (state)
      S_FETCH:  i_req  = !boot;
      S_EXEC:   retire = is_flow;
      S_MEM: begin
        d_req  = 1'b1;
        d_we   = (op == OP_SW);
        retire = d_ack && (op == OP_SW);
      end
      S_WB:     retire = 1'b1;
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

  assign i_addr  = pc;
  assign pc_o    = pc;
  assign d_addr  = res;
  assign d_wdata = opb;
  assign illegal = ill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      ir    <= '0;
      rf    <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      ill_q <= 1'b0;
      boot  <= 1'b1;
    end else begin
      boot <= 1'b0;
      unique case (state)
        S_FETCH:
          if (i_req && i_ack) ir <= i_rdata;
        S_DECODE: begin
          opa <= ra_val;
          opb <= rb_val;
          if (is_bad) ill_q <= 1'b1;
        end
        S_EXEC: begin
          res <= alu_y;
          if (op == OP_BEQ || op == OP_BNE)
            pc <= taken ? br_tgt : pc2;
          else if (op == OP_J)
            pc <= j_tgt;
        end
        S_MEM:
          if (d_ack) begin
            if (op == OP_LW) res <= d_rdata;
            else             pc  <= pc2;
          end
        S_WB: begin
          if (dst != 3'd0) rf[dst] <= res;
          pc <= pc2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_mc_core.sv
// Bench for risc_mc_core: directed programs plus random programs
// checked against an instruction-level model, with and without waits.
module tb_risc_mc_core;

  logic        clk, rst;
  logic        i_req, i_ack;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        retire, halted, illegal;
  logic [15:0] pc_o;

  risc_mc_core #(.DATA_W(16), .PC_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .retire(retire), .halted(halted), .illegal(illegal), .pc_o(pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;

  logic [15:0] imem [int];
  logic [15:0] dmem [int];
  logic [15:0] dmem_init [int];

  bit manual = 1'b1;
  int max_delay = 0;
  int unstable = 0;
  int overlap = 0;
  int halt_req = 0;
  int cyc = 0;
  int ret_cnt = 0;
  int ret_q[$];
  int f_q[$];

  int m_mem [int];
  int m_ret;
  int m_pc;
  int m_ill;
  int m_lat[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  function automatic logic [15:0] enc_r(int op, int ra, int rb, int rd);
    return 16'((op << 12) | (ra << 9) | (rb << 6) | (rd << 3));
  endfunction

  function automatic logic [15:0] enc_m(int op, int ra, int rb, int imm);
    return 16'((op << 12) | (ra << 9) | (rb << 6) | (imm & 63));
  endfunction

  function automatic logic [31:0] fq_at(int i);
    return (i < f_q.size()) ? 32'(f_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dget(int k);
    return dmem.exists(k) ? {16'h0, dmem[k]} : 32'hxxxx_xxxx;
  endfunction

  // Memory responder: acks after a random number of wait cycles
  initial begin
    bit ib, db;
    int icnt, dcnt, k;
    logic [15:0] ia, da, dwd;
    logic dwe;
    ib = 0; db = 0; icnt = 0; dcnt = 0;
    ia = 0; da = 0; dwd = 0; dwe = 0;
    i_ack = 0; d_ack = 0; i_rdata = 0; d_rdata = 0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        i_ack = 0;
        d_ack = 0;
        if (rst) begin
          ib = 0;
          db = 0;
        end else begin
          if (i_req) begin
            if (!ib) begin
              ib = 1;
              ia = i_addr;
              icnt = int'($urandom_range(0, max_delay));
            end else if (i_addr !== ia) unstable++;
            if (icnt == 0) begin
              k = int'(i_addr) >> 1;
              i_rdata = imem.exists(k) ? imem[k] : 16'hF000;
              i_ack = 1;
              ib = 0;
            end else icnt--;
          end else ib = 0;
          if (d_req) begin
            if (!db) begin
              db = 1;
              da = d_addr; dwe = d_we; dwd = d_wdata;
              dcnt = int'($urandom_range(0, max_delay));
            end else if (d_addr !== da || d_we !== dwe || d_wdata !== dwd)
              unstable++;
            if (dcnt == 0) begin
              k = int'(d_addr);
              if (d_we) dmem[k] = d_wdata;
              d_rdata = dmem.exists(k) ? dmem[k] : 16'h0;
              d_ack = 1;
              db = 0;
            end else dcnt--;
          end else db = 0;
        end
      end
    end
  end

  // Observer: retire pulses, accepted fetches, port overlap
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        ret_cnt = 0;
        ret_q.delete();
        f_q.delete();
      end else begin
        if (retire) begin
          ret_cnt++;
          ret_q.push_back(cyc);
        end
        if (i_req && i_ack) f_q.push_back(int'(i_addr));
        if (i_req && d_req) overlap++;
        if (halted && (i_req || d_req)) halt_req++;
      end
    end
  end

  // Instruction-level reference: executes the program architecturally
  task automatic model_run();
    int r[8];
    int pc, steps, w, op, ra, rb, rd, imm6, imm12, s, a, b, addr, lat;
    bit stop;
    m_mem.delete();
    foreach (dmem_init[k]) m_mem[k] = int'(dmem_init[k]);
    m_ret = 0; m_ill = 0; m_lat.delete();
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0; steps = 0; stop = 0;
    while (!stop && steps < 4000) begin
      steps++;
      w = imem.exists(pc / 2) ? int'(imem[pc / 2]) : 'hF000;
      op = (w >> 12) & 15; ra = (w >> 9) & 7;
      rb = (w >> 6) & 7;   rd = (w >> 3) & 7;
      imm6 = w & 63;       imm12 = w & 'hFFF;
      s = (imm6 >= 32) ? imm6 - 64 : imm6;
      a = r[ra]; b = r[rb];
      addr = (a + s) & 'hFFFF;
      lat = 4;
      case (op)
        0: begin
          if (rb != 0) r[rb] = m_mem.exists(addr) ? m_mem[addr] : 0;
          lat = 5;
        end
        1: m_mem[addr] = b;
        2: r[rd] = (a + b) & 'hFFFF;
        3: r[rd] = (a - b) & 'hFFFF;
        4: r[rd] = (~a) & 'hFFFF;
        5: r[rd] = (a << (b % 16)) & 'hFFFF;
        6: r[rd] = a >> (b % 16);
        7: r[rd] = a & b;
        8: r[rd] = a | b;
        9: r[rd] = (a < b) ? 1 : 0;
        default: ;
      endcase
      r[0] = 0;
      if (op == 'hF || op == 'hA || op == 'hE) begin
        stop = 1;
        m_ill = (op != 'hF) ? 1 : 0;
      end else begin
        if (op == 'hB || op == 'hC) begin
          lat = 3;
          if ((a == b) == (op == 'hB)) pc = (pc + 2 + 2 * s) & 'hFFFF;
          else pc = (pc + 2) & 'hFFFF;
        end else if (op == 'hD) begin
          lat = 3;
          pc = ((pc + 2) & 'hE000) | (imm12 << 1);
        end else pc = (pc + 2) & 'hFFFF;
        m_ret++;
        m_lat.push_back(lat);
      end
    end
    m_pc = pc;
  endtask

  task automatic wait_halt(input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      step();
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic run_prog();
    dmem = dmem_init;
    rst = 1;
    step();
    step();
    rst = 0;
    wait_halt(5000);
  endtask

  task automatic gen_prog();
    int pc = 0;
    imem.delete();
    dmem_init.delete();
    for (int r = 1; r < 8; r++) begin
      dmem_init[r] = 16'($urandom);
      imem[pc++] = enc_m(0, 0, r, r);
    end
    for (int i = 0; i < 30; i++) begin
      int kind = int'($urandom_range(0, 9));
      int ra = int'($urandom_range(0, 7));
      int rb = int'($urandom_range(0, 7));
      int rd = int'($urandom_range(0, 7));
      if (kind <= 5)
        imem[pc++] = enc_r(int'($urandom_range(2, 9)), ra, rb, rd);
      else if (kind == 6)
        imem[pc++] = enc_m(0, ra, rb, int'($urandom_range(0, 63)));
      else if (kind == 7)
        imem[pc++] = enc_m(1, ra, rb, int'($urandom_range(0, 63)));
      else
        imem[pc++] = enc_m(kind == 8 ? 'hB : 'hC, ra,
                           ($urandom_range(0, 1) != 0) ? ra : rb,
                           int'($urandom_range(1, 3)));
    end
    for (int r = 1; r < 8; r++) imem[pc++] = enc_m(1, 0, r, 20 + r);
    imem[pc] = 16'hF000;
  endtask

  task automatic rand_run(input int maxd);
    max_delay = maxd;
    run_prog();
    check("rnd_halted", halted, 1);
    check("rnd_illegal", illegal, m_ill);
    check("rnd_pc", pc_o, m_pc);
    check("rnd_retire", ret_cnt, m_ret);
    check("rnd_mem_size", dmem.size(), m_mem.size());
    foreach (m_mem[k]) check($sformatf("rnd_mem_%0h", k), dget(k), m_mem[k]);
    check("rnd_overlap", overlap, 0);
    check("rnd_stable", unstable, 0);
    check("rnd_halt_req", halt_req, 0);
    if (maxd == 0) begin
      check("rnd_lat_cnt", ret_q.size(), m_lat.size());
      for (int k = 1; k < ret_q.size() && k < m_lat.size(); k++)
        check($sformatf("rnd_lat_%0d", k), ret_q[k] - ret_q[k-1], m_lat[k]);
    end
  endtask

  initial begin
    rst = 1;
    manual = 1;
    step();
    step();
    check("rst_i_req", i_req, 0);
    check("rst_d_req", d_req, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc", pc_o, 0);
    rst = 0;
    step();
    check("first_i_req", i_req, 1);
    check("first_i_addr", i_addr, 0);

    // LW/LW/ADD/SW/HALT
    manual = 0;
    imem.delete();
    imem[0] = enc_m(0, 0, 1, 0);
    imem[1] = enc_m(0, 0, 2, 1);
    imem[2] = enc_r(2, 1, 2, 3);
    imem[3] = enc_m(1, 0, 3, 2);
    imem[4] = 16'hF000;
    dmem_init.delete();
    dmem_init[0] = 16'd1;
    dmem_init[1] = 16'd2;
    run_prog();
    check("add_m2", dget(2), 3);
    check("add_retire", ret_cnt, 4);
    check("add_pc", pc_o, 8);
    check("add_illegal", illegal, 0);

    // Reset during a fetch wait, ack arrives after the reset
    imem.delete();
    for (int r = 1; r < 8; r++) imem[r - 1] = enc_m(1, 0, r, 20 + r);
    imem[7] = 16'hF000;
    for (int r = 1; r < 8; r++) dmem[20 + r] = 16'h1234;
    manual = 1;
    i_ack = 0;
    rst = 1;
    step();
    rst = 0;
    step();
    check("mf_req", i_req, 1);
    step();
    rst = 1;
    step();
    check("mf_req_rst", i_req, 0);
    rst = 0;
    i_ack = 1;
    i_rdata = 16'h2248;
    step();
    check("mf_refetch_req", i_req, 1);
    check("mf_refetch_addr", i_addr, 0);
    check("mf_no_retire", ret_cnt, 0);
    i_ack = 0;
    manual = 0;
    wait_halt(500);
    for (int r = 1; r < 8; r++)
      check($sformatf("mf_reg%0d", r), dget(20 + r), 0);
    check("mf_retire", ret_cnt, 7);

    // Branches and jump
    dmem_init.delete();
    imem.delete();
    imem[0] = 16'h2000;
    imem[1] = 16'h2000;
    imem[2] = enc_m('hB, 0, 0, 3);
    run_prog();
    check("beq_next", fq_at(3), 12);
    imem[2] = enc_m('hC, 0, 0, 3);
    run_prog();
    check("bne_next", fq_at(3), 6);
    imem.delete();
    imem[0] = 16'hDFFF;
    imem['h1FFE / 2] = 16'hD000;
    imem['h2000 / 2] = 16'hD010;
    run_prog();
    check("j_far", fq_at(1), 'h1FFE);
    check("j_next", fq_at(3), 'h2020);

    // r0 write discard, shift amount masking, unsigned SLT
    imem.delete();
    imem[0] = enc_m(0, 0, 1, 0);
    imem[1] = enc_m(0, 0, 2, 1);
    imem[2] = enc_m(0, 0, 5, 2);
    imem[3] = enc_m(0, 0, 6, 3);
    imem[4] = enc_r(2, 1, 1, 0);
    imem[5] = enc_m(1, 0, 0, 10);
    imem[6] = enc_r(5, 1, 2, 4);
    imem[7] = enc_m(1, 0, 4, 11);
    imem[8] = enc_r(9, 5, 6, 7);
    imem[9] = enc_m(1, 0, 7, 12);
    imem[10] = 16'hF000;
    dmem_init[0] = 16'd5;
    dmem_init[1] = 16'd17;
    dmem_init[2] = 16'hFFFF;
    dmem_init[3] = 16'd1;
    dmem_init[10] = 16'h55;
    dmem_init[12] = 16'h55;
    run_prog();
    check("r0_zero", dget(10), 0);
    check("shl_mask", dget(11), 10);
    check("slt_unsigned", dget(12), 0);

    // Undefined opcodes
    dmem_init.delete();
    imem.delete();
    imem[0] = 16'hA000;
    run_prog();
    check("ill_a_halted", halted, 1);
    check("ill_a_flag", illegal, 1);
    check("ill_a_retire", ret_cnt, 0);
    begin
      int nreq = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (i_req) nreq++;
      end
      check("ill_a_no_req", nreq, 0);
    end
    check("ill_a_pc", pc_o, 0);
    imem[0] = 16'hE000;
    run_prog();
    check("ill_e_flag", illegal, 1);

    for (int s = 0; s < 3; s++) begin
      gen_prog();
      model_run();
      rand_run(0);
      rand_run(5);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
